// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmit scheduler.
module uart_tx_fifo
  import uart_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [UART_BYTE_W-1:0] wdata,
  output logic [UART_BYTE_W-1:0] rdata,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   empty
);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~flush & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules store bytes from the LSU into the UART one frame at a time,
// stalling the pipeline when the transmit FIFO would overflow.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [UART_BYTE_W-1:0] st_data,
  input  logic                   flush,
  input  logic                   tx_done,
  output logic                   stall,
  output logic                   byte_ready,
  output logic                   t_byte,
  output logic [UART_BYTE_W-1:0] data_in,
  output logic [AW:0]            count,
  output logic                   busy
);

  tx_state_e              state_q, state_d;
  logic [UART_BYTE_W-1:0] data_in_q, data_in_d;
  logic [UART_BYTE_W-1:0] fifo_rdata;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, avail;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(st_data),
    .rdata(fifo_rdata),
    .count(count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // The head is consumed on the LOAD->START edge; a flush in LOAD cancels it.
  assign pop   = (state_q == LOAD) & ~flush;
  assign stall = st_valid & fifo_full & ~pop;
  assign push  = st_valid & ~stall;
  // A byte being flushed this cycle must not start a new frame.
  assign avail = ~fifo_empty & ~flush;

  always_comb begin
    state_d   = state_q;
    data_in_d = data_in_q;
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          state_d   = LOAD;
          data_in_d = fifo_rdata;
        end
      end
      LOAD:  state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (avail) begin
            state_d   = LOAD;
            data_in_d = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      data_in_q <= data_in_d;
    end
  end

  assign byte_ready = (state_q == LOAD);
  assign t_byte     = (state_q == START);
  assign data_in    = data_in_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized traffic
// checked against a queue-based transaction model.
module tb_uart_tx_sched;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       st_valid = 1'b0;
  logic [7:0] st_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_done = 1'b0;
  logic       stall, byte_ready, t_byte, busy;
  logic [7:0] data_in;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  // Model: queued bytes, frame phase (0 idle, 1 byte offered, 2 start, 3 on the wire),
  // latched byte, and the order in which frames should be offered.
  logic [7:0] fq[$];
  logic [7:0] exp_sent[$];
  logic [7:0] dut_sent[$];
  int         ph;
  logic [7:0] m_data;
  logic       m_stall;

  uart_tx_sched #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_data   (st_data),
    .flush     (flush),
    .tx_done   (tx_done),
    .stall     (stall),
    .byte_ready(byte_ready),
    .t_byte    (t_byte),
    .data_in   (data_in),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && byte_ready) dut_sent.push_back(data_in);

  task automatic model_reset();
    fq.delete();
    exp_sent.delete();
    dut_sent.delete();
    ph     = 0;
    m_data = 8'h00;
  endtask

  // Apply this cycle's inputs, predict the stall, and move to the sampling point.
  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic t);
    st_valid = v;
    st_data  = d;
    flush    = f;
    tx_done  = t;
    m_stall  = v && (fq.size() == DEPTH) && !(ph == 1 && !f);
    @(negedge clk);
  endtask

  // Advance one clock and update the model with the inputs that were applied.
  task automatic step();
    bit         pop_m, avail;
    int         nph;
    logic [7:0] head;
    pop_m = (ph == 1) && !flush;
    avail = (fq.size() > 0) && !flush;
    head  = (fq.size() > 0) ? fq[0] : 8'h00;
    nph   = ph;
    @(posedge clk);
    case (ph)
      0: if (avail) begin nph = 1; m_data = head; exp_sent.push_back(head); end
      1: nph = 2;
      2: nph = 3;
      default: if (tx_done) begin
        if (avail) begin nph = 1; m_data = head; exp_sent.push_back(head); end
        else nph = 0;
      end
    endcase
    if (flush) fq.delete();
    else begin
      if (pop_m) void'(fq.pop_front());
      if (st_valid && !m_stall) fq.push_back(st_data);
    end
    ph = nph;
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    st_valid = 1'b1;
    #12;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count actual=%0d required=0", count); end
    total++; if (byte_ready !== 1'b0 || t_byte !== 1'b0) begin bad++;
      $display("FAIL reset_strobes actual=%b%b required=00", byte_ready, t_byte); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
    total++; if (data_in !== 8'h00) begin bad++; $display("FAIL reset_data actual=%h required=00", data_in); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall actual=%b required=0", stall); end
    st_valid = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic test_single_byte();
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL single_stall actual=%b required=0", stall); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (byte_ready !== 1'b0 || busy !== 1'b1 || count !== 4'd1) begin bad++;
      $display("FAIL single_n1 actual=br%b busy%b cnt%0d required=br0 busy1 cnt1", byte_ready, busy, count); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (byte_ready !== 1'b1 || t_byte !== 1'b0 || data_in !== 8'h41) begin bad++;
      $display("FAIL single_load actual=br%b tb%b d%h required=br1 tb0 d41", byte_ready, t_byte, data_in); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (t_byte !== 1'b1 || byte_ready !== 1'b0 || count !== 4'd0) begin bad++;
      $display("FAIL single_start actual=br%b tb%b cnt%0d required=br0 tb1 cnt0", byte_ready, t_byte, count); end
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h00, 1'b0, i == 9);
      total++; if (busy !== 1'b1 || byte_ready !== 1'b0 || t_byte !== 1'b0) begin bad++;
        $display("FAIL single_wait%0d actual=busy%b br%b tb%b required=busy1 br0 tb0", i, busy, byte_ready, t_byte); end
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy actual=%b required=0", busy); end
    step();
    dut_sent.delete(); exp_sent.delete();
  endtask

  task automatic test_fill_collision();
    for (int i = 0; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fill_stall%0d actual=%b required=0", i, stall); end
      step();
    end
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    total++; if (stall !== 1'b1 || count !== 4'd8) begin bad++;
      $display("FAIL fill_full actual=stall%b cnt%0d required=stall1 cnt8", stall, count); end
    step();
    drive(1'b1, 8'h09, 1'b0, 1'b1);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fill_full2 actual=%b required=1", stall); end
    step();
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    total++; if (stall !== 1'b0 || byte_ready !== 1'b1 || data_in !== 8'h01) begin bad++;
      $display("FAIL collide actual=stall%b br%b d%h required=stall0 br1 d01", stall, byte_ready, data_in); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (count !== 4'd8) begin bad++; $display("FAIL collide_count actual=%0d required=8", count); end
    step();
    for (int i = 0; i < 100; i++) begin drive(1'b0, 8'h00, 1'b0, 1'b1); step(); end
    total++; if (dut_sent.size() != 10) begin bad++;
      $display("FAIL fill_order_len actual=%0d required=10", dut_sent.size()); end
    else for (int k = 0; k < 10; k++) begin
      total++; if (dut_sent[k] !== 8'(k)) begin bad++;
        $display("FAIL fill_order[%0d] actual=%h required=%h", k, dut_sent[k], 8'(k)); end
    end
    dut_sent.delete(); exp_sent.delete();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0); step(); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre actual=%0d required=5", count); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (count !== 4'd0 || busy !== 1'b1) begin bad++;
      $display("FAIL flush_post actual=cnt%0d busy%b required=cnt0 busy1", count, busy); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      total++; if (byte_ready !== 1'b0 || busy !== 1'b0) begin bad++;
        $display("FAIL flush_idle%0d actual=br%b busy%b required=br0 busy0", i, byte_ready, busy); end
      step();
    end
    total++; if (dut_sent.size() != 1) begin bad++;
      $display("FAIL flush_frames actual=%0d required=1", dut_sent.size()); end
    dut_sent.delete(); exp_sent.delete();
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      total++; if (busy !== 1'b0 || byte_ready !== 1'b0 || count !== 4'd0) begin bad++;
        $display("FAIL spur_idle%0d actual=busy%b br%b cnt%0d required=0 0 0", i, busy, byte_ready, count); end
      step();
    end
    drive(1'b1, 8'h5A, 1'b0, 1'b0); step();
    drive(1'b1, 8'h5B, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (byte_ready !== 1'b1 || data_in !== 8'h5A) begin bad++;
      $display("FAIL spur_load actual=br%b d%h required=br1 d5A", byte_ready, data_in); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (t_byte !== 1'b1 || count !== 4'd1) begin bad++;
      $display("FAIL spur_after_load actual=tb%b cnt%0d required=tb1 cnt1", t_byte, count); end
    step();
    for (int i = 0; i < 40; i++) begin drive(1'b0, 8'h00, 1'b0, 1'b1); step(); end
    total++; if (dut_sent.size() != 2 || busy !== 1'b0) begin bad++;
      $display("FAIL spur_drain actual=frames%0d busy%b required=frames2 busy0", dut_sent.size(), busy); end
    dut_sent.delete(); exp_sent.delete();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 8'h77 + 8'(i), 1'b0, 1'b0); step(); end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (t_byte !== 1'b1) begin bad++; $display("FAIL arst_pre actual=%b required=1", t_byte); end
    #2 reset = 1'b0;
    #1;
    total++; if (t_byte !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL arst_outs actual=tb%b br%b busy%b required=000", t_byte, byte_ready, busy); end
    total++; if (count !== 4'd0 || data_in !== 8'h00) begin bad++;
      $display("FAIL arst_state actual=cnt%0d d%h required=cnt0 d00", count, data_in); end
    model_reset();
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic test_random();
    logic v, f, t;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 60);
      f = ($urandom_range(0, 99) < 3);
      t = ($urandom_range(0, 99) < 30);
      d = 8'($urandom);
      drive(v, d, f, t);
      total++; if (stall !== m_stall) begin bad++; $display("FAIL rnd_stall@%0d actual=%b required=%b", i, stall, m_stall); end
      total++; if (count !== 4'(fq.size())) begin bad++;
        $display("FAIL rnd_count@%0d actual=%0d required=%0d", i, count, fq.size()); end
      total++; if (byte_ready !== (ph == 1) || t_byte !== (ph == 2)) begin bad++;
        $display("FAIL rnd_strobes@%0d actual=br%b tb%b required=br%b tb%b", i, byte_ready, t_byte, ph == 1, ph == 2); end
      total++; if (busy !== (ph != 0 || fq.size() != 0)) begin bad++;
        $display("FAIL rnd_busy@%0d actual=%b required=%b", i, busy, ph != 0 || fq.size() != 0); end
      total++; if (data_in !== m_data) begin bad++; $display("FAIL rnd_data@%0d actual=%h required=%h", i, data_in, m_data); end
      step();
    end
    for (int i = 0; i < 60; i++) begin drive(1'b0, 8'h00, 1'b0, 1'b1); step(); end
    total++; if (dut_sent.size() != exp_sent.size()) begin bad++;
      $display("FAIL rnd_frames actual=%0d required=%0d", dut_sent.size(), exp_sent.size()); end
    else for (int k = 0; k < exp_sent.size(); k++) begin
      total++; if (dut_sent[k] !== exp_sent[k]) begin bad++;
        $display("FAIL rnd_order[%0d] actual=%h required=%h", k, dut_sent[k], exp_sent[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_collision();
    test_flush();
    test_spurious();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
